// File: rtl/prio_pick.sv
// Combinational circular priority search: scans start, start-1, ..., 0, N-1, ...
// and reports the first set request bit.
module prio_pick #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      int p;
      idx   = '0;
      found = 1'b0;
      p     = 0;
      for (int k = 0; k < N; k++) begin
         // wrap at N-1 rather than 2^W-1 so non-power-of-two N never yields idx >= N
         p = int'(start) - k;
         if (p < 0) p = p + N;
         if (!found && req[p]) begin
            found = 1'b1;
            idx   = W'(p);
         end
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) request encoder, fixed-priority or round-robin,
// with a single-entry valid/ready output stage.
module prio_encoder_rr #(
   parameter int  N       = 8,
   parameter int  RR_MODE = 0,
   localparam int W       = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_multi
);

   logic [W-1:0] ptr_q, ptr_d;
   logic         valid_q, valid_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] onehot_q, onehot_d;
   logic         multi_q, multi_d;

   logic [W-1:0] start;
   logic [W-1:0] pick_idx;
   logic         pick_found;
   logic         slot_free;
   logic         load;

   assign start = (RR_MODE != 0) ? ptr_q : W'(N - 1);

   prio_pick #(.N(N), .W(W)) u_pick (
      .req   (req),
      .start (start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign slot_free = !valid_q || out_ready;
   assign load      = en && pick_found && slot_free;

   always_comb begin
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      multi_d  = multi_q;
      if (load) begin
         valid_d  = 1'b1;
         idx_d    = pick_idx;
         onehot_d = N'(1) << pick_idx;
         multi_d  = |(req & (req - 1'b1));
         // last winner drops to lowest priority
         if (RR_MODE != 0)
            ptr_d = (pick_idx == '0) ? W'(N - 1) : pick_idx - 1'b1;
      end else if (slot_free) begin
         valid_d  = 1'b0;
         idx_d    = '0;
         onehot_d = '0;
         multi_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q    <= W'(N - 1);
         valid_q  <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
         multi_q  <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
         multi_q  <= multi_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_idx    = idx_q;
   assign out_onehot = onehot_q;
   assign out_multi  = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench: fixed N=8, round-robin N=8 and round-robin N=5 instances
// driven from shared stimulus.
module tb_prio_encoder_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic       out_ready;

   logic       f_valid, f_multi;
   logic [2:0] f_idx;
   logic [7:0] f_oh;
   logic       r_valid, r_multi;
   logic [2:0] r_idx;
   logic [7:0] r_oh;
   logic       q_valid, q_multi;
   logic [2:0] q_idx;
   logic [4:0] q_oh;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prio_encoder_rr #(.N(8), .RR_MODE(0)) u_fix (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
      .out_valid(f_valid), .out_idx(f_idx), .out_onehot(f_oh), .out_multi(f_multi));

   prio_encoder_rr #(.N(8), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
      .out_valid(r_valid), .out_idx(r_idx), .out_onehot(r_oh), .out_multi(r_multi));

   prio_encoder_rr #(.N(5), .RR_MODE(1)) u_rr5 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req[4:0]), .out_ready(out_ready),
      .out_valid(q_valid), .out_idx(q_idx), .out_onehot(q_oh), .out_multi(q_multi));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b1; req = 8'h00; out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
      tick(); tick();
      n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", f_valid); end
      n_checks++; if (f_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", f_idx); end
      n_checks++; if (f_oh !== 8'h00) begin n_fail++; $display("FAIL reset_onehot got %h want 00", f_oh); end
      n_checks++; if (f_multi !== 1'b0) begin n_fail++; $display("FAIL reset_multi got %0b want 0", f_multi); end
      rst_n = 1'b1;
      tick();
      n_checks++; if (f_valid !== 1'b1 || f_idx !== 3'd7) begin n_fail++; $display("FAIL post_reset_grant got v=%0b idx=%0d want v=1 idx=7", f_valid, f_idx); end
      n_checks++; if (r_idx !== 3'd7) begin n_fail++; $display("FAIL rr_first_grant got %0d want 7", r_idx); end
      rst_n = 1'b0;
      tick();
      n_checks++; if (f_valid !== 1'b0 || f_oh !== 8'h00) begin n_fail++; $display("FAIL reset_midxfer got v=%0b oh=%h want v=0 oh=00", f_valid, f_oh); end
      rst_n = 1'b1;
   endtask

   task automatic test_fixed();
      do_reset();
      req = 8'b0010_0110;
      tick();
      n_checks++; if (f_valid !== 1'b1 || f_idx !== 3'd5) begin n_fail++; $display("FAIL fixed_idx5 got v=%0b idx=%0d want v=1 idx=5", f_valid, f_idx); end
      n_checks++; if (f_oh !== 8'h20) begin n_fail++; $display("FAIL fixed_oh5 got %h want 20", f_oh); end
      n_checks++; if (f_multi !== 1'b1) begin n_fail++; $display("FAIL fixed_multi5 got %0b want 1", f_multi); end
      req = 8'h01;
      tick();
      n_checks++; if (f_idx !== 3'd0 || f_oh !== 8'h01) begin n_fail++; $display("FAIL fixed_idx0 got idx=%0d oh=%h want idx=0 oh=01", f_idx, f_oh); end
      n_checks++; if (f_multi !== 1'b0) begin n_fail++; $display("FAIL fixed_multi0 got %0b want 0", f_multi); end
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 8'b0010_0110;
      tick();
      out_ready = 1'b0; req = 8'h01;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (f_valid !== 1'b1 || f_idx !== 3'd5 || f_oh !== 8'h20 || f_multi !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d] got v=%0b idx=%0d oh=%h m=%0b want v=1 idx=5 oh=20 m=1", c, f_valid, f_idx, f_oh, f_multi);
         end
      end
      out_ready = 1'b1;
      tick();
      n_checks++; if (f_valid !== 1'b1 || f_idx !== 3'd0) begin n_fail++; $display("FAIL b2b_after_stall got v=%0b idx=%0d want v=1 idx=0", f_valid, f_idx); end
      req = 8'h00;
      tick();
      n_checks++;
      if (f_valid !== 1'b0 || f_idx !== 3'd0 || f_oh !== 8'h00 || f_multi !== 1'b0) begin
         n_fail++;
         $display("FAIL drain got v=%0b idx=%0d oh=%h m=%0b want all 0", f_valid, f_idx, f_oh, f_multi);
      end
   endtask

   task automatic test_rr_all();
      logic [2:0] exp_seq [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      do_reset();
      req = 8'hFF;
      for (int c = 0; c < 9; c++) begin
         tick();
         n_checks++;
         if (r_valid !== 1'b1 || r_idx !== exp_seq[c] || r_oh !== (8'h01 << exp_seq[c])) begin
            n_fail++;
            $display("FAIL rr_all[%0d] got v=%0b idx=%0d oh=%h want v=1 idx=%0d", c, r_valid, r_idx, r_oh, exp_seq[c]);
         end
      end
   endtask

   task automatic test_rr_pair();
      logic [2:0] exp_seq [4] = '{3'd7, 3'd0, 3'd7, 3'd0};
      do_reset();
      req = 8'b1000_0001;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (r_valid !== 1'b1 || r_idx !== exp_seq[c]) begin
            n_fail++;
            $display("FAIL rr_pair[%0d] got v=%0b idx=%0d want v=1 idx=%0d", c, r_valid, r_idx, exp_seq[c]);
         end
      end
      out_ready = 1'b0;
      tick(); tick();
      n_checks++; if (r_valid !== 1'b1 || r_idx !== 3'd0) begin n_fail++; $display("FAIL rr_stall got v=%0b idx=%0d want v=1 idx=0", r_valid, r_idx); end
      out_ready = 1'b1;
      tick();
      n_checks++; if (r_valid !== 1'b1 || r_idx !== 3'd7) begin n_fail++; $display("FAIL rr_after_stall got v=%0b idx=%0d want v=1 idx=7", r_valid, r_idx); end
   endtask

   task automatic test_n5();
      logic [2:0] exp_seq [3] = '{3'd4, 3'd0, 3'd4};
      do_reset();
      req = 8'h11;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (q_valid !== 1'b1 || q_idx !== exp_seq[c] || q_oh !== (5'b00001 << exp_seq[c])) begin
            n_fail++;
            $display("FAIL n5_seq[%0d] got v=%0b idx=%0d oh=%b want v=1 idx=%0d", c, q_valid, q_idx, q_oh, exp_seq[c]);
         end
      end
      en = 1'b0;
      tick();
      n_checks++; if (q_valid !== 1'b0 || q_idx !== 3'd0) begin n_fail++; $display("FAIL n5_en_off got v=%0b idx=%0d want v=0 idx=0", q_valid, q_idx); end
      en = 1'b1;
      tick();
      n_checks++; if (q_valid !== 1'b1 || q_idx !== 3'd0) begin n_fail++; $display("FAIL n5_ptr_held got v=%0b idx=%0d want v=1 idx=0", q_valid, q_idx); end
      req = 8'h1F;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++; if (q_idx >= 3'd5) begin n_fail++; $display("FAIL n5_range[%0d] got idx=%0d want <5", c, q_idx); end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; req = 8'h00; out_ready = 1'b1;
      #2;
      test_reset();
      test_fixed();
      test_backpressure();
      test_rr_all();
      test_rr_pair();
      test_n5();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
